// File: rtl/microwave_ctrl_pkg.sv
// microwave_ctrl_pkg
//   Shared constants and the FSM state type for the microwave cook-enable
//   controller.
//   ST_IDLE / ST_COOKING    : one-bit FSM encodings
//   BTN_PRESSED / BTN_RELEASED : levels of the active-low front-panel buttons
package microwave_ctrl_pkg;

   localparam logic ST_IDLE      = 1'b0;
   localparam logic ST_COOKING   = 1'b1;

   localparam logic BTN_PRESSED  = 1'b0;
   localparam logic BTN_RELEASED = 1'b1;

   typedef enum logic {
      IDLE    = ST_IDLE,
      COOKING = ST_COOKING
   } state_t;

endpackage

// File: rtl/mw_sync.sv
// mw_sync
//   One-bit synchronizer: a chain of STAGES flops with asynchronous,
//   active-high reset to RESET_VAL.
//   Ports:
//     clk  in  1  system clock
//     rst  in  1  asynchronous active-high reset
//     d    in  1  asynchronous input
//     q    out 1  synchronized output
module mw_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain <= {STAGES{RESET_VAL}};
      else     chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/microwave_control.sv
// microwave_control
//   Cook-enable controller: decides when the magnetron is energised from the
//   front-panel buttons, the door switch and the timer expiry flag.
//   Optional build macro INPUT_SYNC_EN: when defined, every input passes
//   through a SYNC_STAGES-deep synchronizer (mw_sync) before use.
//   Ports:
//     clk            in   1  system clock
//     rst            in   1  asynchronous active-high reset
//     start          in   1  start button, active-low
//     stop           in   1  stop button, active-low
//     clear          in   1  clear button, active-low
//     closed_door    in   1  door switch, 1 = closed
//     finished_time  in   1  timer expired, 1 = no time remaining
//     magnetron      out  1  magnetron enable, 1 = heating
//
//   state   | meaning
//   IDLE    | magnetron off, waiting for a fresh start press with no kill
//   COOKING | magnetron on until any kill condition appears
module microwave_control
   import microwave_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic stop,
   input  logic clear,
   input  logic closed_door,
   input  logic finished_time,
   output logic magnetron
);

   if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("microwave_control: SYNC_STAGES must be >= 2");
   end

   logic s_start, s_stop, s_clear, s_closed_door, s_finished_time;

`ifdef INPUT_SYNC_EN
   mw_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(BTN_RELEASED)) u_sync_start (
      .clk(clk), .rst(rst), .d(start), .q(s_start));
   mw_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(BTN_RELEASED)) u_sync_stop (
      .clk(clk), .rst(rst), .d(stop), .q(s_stop));
   mw_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(BTN_RELEASED)) u_sync_clear (
      .clk(clk), .rst(rst), .d(clear), .q(s_clear));
   mw_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_door (
      .clk(clk), .rst(rst), .d(closed_door), .q(s_closed_door));
   mw_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_finished (
      .clk(clk), .rst(rst), .d(finished_time), .q(s_finished_time));
`else
   assign s_start         = start;
   assign s_stop          = stop;
   assign s_clear         = clear;
   assign s_closed_door   = closed_door;
   assign s_finished_time = finished_time;
`endif

   logic   prev_start;
   logic   start_press;
   logic   kill;
   state_t state;

   assign start_press = (prev_start == BTN_RELEASED) && (s_start == BTN_PRESSED);
   assign kill        = (s_stop == BTN_PRESSED) || (s_clear == BTN_PRESSED) ||
                        !s_closed_door || s_finished_time;

   // magnetron is loaded from the next-state decision so it tracks state
   // with a single clock of latency from the qualifying edge. Plain 'if'
   // treats an X condition as false, so unknown inputs never start cooking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_start <= BTN_RELEASED;
         state      <= IDLE;
         magnetron  <= 1'b0;
      end else begin
         prev_start <= s_start;
         case (state)
            IDLE: begin
               if (start_press && !kill) begin
                  state     <= COOKING;
                  magnetron <= 1'b1;
               end
            end
            COOKING: begin
               if (kill) begin
                  state     <= IDLE;
                  magnetron <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               magnetron <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_microwave_control.sv
module tb_microwave_control;

   logic clk = 1'b0;
   logic rst;
   logic start, stop, clear, closed_door, finished_time;
   logic magnetron;

   int checks = 0;
   int errors = 0;

   microwave_control #(.SYNC_STAGES(2)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .stop(stop),
      .clear(clear),
      .closed_door(closed_door),
      .finished_time(finished_time),
      .magnetron(magnetron)
   );

   always #5 clk = ~clk;

`ifdef INPUT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   // advance to 1 time unit after the next rising edge
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_inputs();
      start = 1'b1; stop = 1'b1; clear = 1'b1;
      closed_door = 1'b1; finished_time = 1'b0;
   endtask

   task automatic press_start();
      start = 1'b0;
      tick(1);
      start = 1'b1;
      tick(LAT);
   endtask

   task automatic test_reset();
      logic [4:0] pat;
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pat = 5'(i * 7 + 3);
         start = pat[0]; stop = pat[1]; clear = pat[2];
         closed_door = pat[3]; finished_time = pat[4];
         tick(1);
         checks++;
         if (magnetron !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold[%0d] magnetron=%b expected=0", i, magnetron);
         end
      end
      idle_inputs();
      tick(1);
      rst = 1'b0;
      tick(4);
      checks++;
      if (magnetron !== 1'b0) begin
         errors++;
         $display("FAIL reset_release magnetron=%b expected=0", magnetron);
      end
   endtask

   task automatic test_normal_cook();
      idle_inputs();
      tick(2);
      start = 1'b0;
      tick(LAT);
      checks++;
      if (magnetron !== 1'b1) begin
         errors++;
         $display("FAIL cook_on magnetron=%b expected=1", magnetron);
      end
      start = 1'b1;
      tick(3);
      checks++;
      if (magnetron !== 1'b1) begin
         errors++;
         $display("FAIL cook_hold magnetron=%b expected=1", magnetron);
      end
      stop = 1'b0;
      tick(LAT + 1);
      stop = 1'b1;
      tick(LAT + 1);
   endtask

   // 0: door open, 1: timer expired, 2: stop held, 3: clear held
   task automatic apply_kill(input int k, input logic active);
      case (k)
         0: closed_door   = active ? 1'b0 : 1'b1;
         1: finished_time = active ? 1'b1 : 1'b0;
         2: stop          = active ? 1'b0 : 1'b1;
         default: clear   = active ? 1'b0 : 1'b1;
      endcase
   endtask

   task automatic test_interlocks();
      for (int k = 0; k < 4; k++) begin
         idle_inputs();
         tick(LAT + 1);
         apply_kill(k, 1'b1);
         tick(LAT + 1);
         press_start();
         tick(1);
         checks++;
         if (magnetron !== 1'b0) begin
            errors++;
            $display("FAIL interlock[%0d] magnetron=%b expected=0", k, magnetron);
         end
         apply_kill(k, 1'b0);
         tick(LAT + 1);
         checks++;
         if (magnetron !== 1'b0) begin
            errors++;
            $display("FAIL interlock_release[%0d] magnetron=%b expected=0", k, magnetron);
         end
      end
   endtask

   task automatic test_kill();
      for (int k = 0; k < 4; k++) begin
         idle_inputs();
         tick(LAT + 1);
         press_start();
         checks++;
         if (magnetron !== 1'b1) begin
            errors++;
            $display("FAIL kill_precook[%0d] magnetron=%b expected=1", k, magnetron);
         end
         apply_kill(k, 1'b1);
         tick(LAT - 1);
         checks++;
         if (magnetron !== 1'b1) begin
            errors++;
            $display("FAIL kill_early[%0d] magnetron=%b expected=1", k, magnetron);
         end
         tick(1);
         checks++;
         if (magnetron !== 1'b0) begin
            errors++;
            $display("FAIL kill_off[%0d] magnetron=%b expected=0", k, magnetron);
         end
         apply_kill(k, 1'b0);
         tick(LAT + 2);
         checks++;
         if (magnetron !== 1'b0) begin
            errors++;
            $display("FAIL kill_no_resume[%0d] magnetron=%b expected=0", k, magnetron);
         end
      end
   endtask

   task automatic test_rearm();
      idle_inputs();
      tick(LAT + 1);
      start = 1'b0;
      tick(LAT);
      checks++;
      if (magnetron !== 1'b1) begin
         errors++;
         $display("FAIL rearm_first magnetron=%b expected=1", magnetron);
      end
      stop = 1'b0;
      tick(LAT + 1);
      stop = 1'b1;
      tick(LAT + 3);
      checks++;
      if (magnetron !== 1'b0) begin
         errors++;
         $display("FAIL rearm_held magnetron=%b expected=0", magnetron);
      end
      start = 1'b1;
      tick(LAT + 1);
      checks++;
      if (magnetron !== 1'b0) begin
         errors++;
         $display("FAIL rearm_release magnetron=%b expected=0", magnetron);
      end
      start = 1'b0;
      tick(LAT);
      checks++;
      if (magnetron !== 1'b1) begin
         errors++;
         $display("FAIL rearm_fresh magnetron=%b expected=1", magnetron);
      end
      start = 1'b1;
      tick(1);
   endtask

   task automatic test_async_reset();
      checks++;
      if (magnetron !== 1'b1) begin
         errors++;
         $display("FAIL areset_precook magnetron=%b expected=1", magnetron);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (magnetron !== 1'b0) begin
         errors++;
         $display("FAIL areset_immediate magnetron=%b expected=0", magnetron);
      end
      #2 rst = 1'b0;
      tick(LAT + 3);
      checks++;
      if (magnetron !== 1'b0) begin
         errors++;
         $display("FAIL areset_after magnetron=%b expected=0", magnetron);
      end
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      tick(LAT + 1);
      press_start();
      finished_time = 1'b1;
      tick(LAT);
      checks++;
      if (magnetron !== 1'b0) begin
         errors++;
         $display("FAIL b2b_expire magnetron=%b expected=0", magnetron);
      end
      finished_time = 1'b0;
      tick(LAT + 1);
      press_start();
      checks++;
      if (magnetron !== 1'b1) begin
         errors++;
         $display("FAIL b2b_recook magnetron=%b expected=1", magnetron);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_normal_cook();
      test_interlocks();
      test_kill();
      test_rearm();
      test_async_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
